// File: rtl/lvds_clock_sync.sv
// lvds_clock_sync
//
// Holds off the LVDS transmit path until the DDR clock domain has run stably
// for START_DELAY cycles. It then raises a registered ready flag and emits a
// one-cycle strobe once per 32-bit frame (16 DDR cycles).
//
// Optional watchdog (macro LVDS_CLOCK_SYNC_WATCHDOG_EN):
//   When defined, the FPGA system clock is sampled as data through a 3-flop
//   synchronizer. If no edge of it is seen for TIMEOUT cycles, the system clock
//   is declared lost: ready drops and the start delay restarts from zero once
//   edges resume.
//   When undefined, i_sys_clk is ignored and the system clock is never lost.
//
// Ports:
//   i_ddr_clk         in   sole clock; every register uses its rising edge
//   i_rst_b           in   asynchronous active-low reset
//   i_sys_clk         in   FPGA system clock, sampled as data only
//   o_lvds_ready_ddr  out  LVDS transmit path ready (registered)
//   o_data_sbe_ddr    out  one-cycle frame strobe, once every 16 ready cycles

module lvds_clock_sync #(
    parameter logic [9:0] START_DELAY = 10'd1000,
    parameter logic [6:0] TIMEOUT     = 7'd100
) (
    input  logic i_ddr_clk,
    input  logic i_rst_b,
    input  logic i_sys_clk,
    output logic o_lvds_ready_ddr,
    output logic o_data_sbe_ddr
);

    logic       sys_lost;
    logic [9:0] delay_q, delay_d;
    logic       ready_q, ready_d;
    logic [3:0] frame_q, frame_d;

`ifdef LVDS_CLOCK_SYNC_WATCHDOG_EN
    logic [2:0] sync_q, sync_d;
    logic [6:0] timeout_q, timeout_d;
    logic       sys_edge;

    // Both edges of the system clock count as activity.
    assign sys_edge = sync_q[2] ^ sync_q[1];
    assign sys_lost = (timeout_q == TIMEOUT);

    always_comb begin
        sync_d    = {sync_q[1:0], i_sys_clk};
        timeout_d = timeout_q;
        // An edge takes priority over saturation, so a late edge still clears
        // the counter before it is declared lost.
        if (sys_edge) begin
            timeout_d = 7'd0;
        end else if (timeout_q != TIMEOUT) begin
            timeout_d = timeout_q + 7'd1;
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sync_q    <= 3'b000;
            timeout_q <= 7'd0;
        end else begin
            sync_q    <= sync_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_sys_clk;

    assign unused_sys_clk = i_sys_clk;
    assign sys_lost       = 1'b0;
`endif

    always_comb begin
        delay_d = delay_q;
        if (sys_lost) begin
            delay_d = 10'd0;
        end else if (delay_q != START_DELAY) begin
            delay_d = delay_q + 10'd1;
        end

        ready_d = (delay_q == START_DELAY) && !sys_lost;

        // Frame phase is held at zero while not ready, so the first strobe
        // lands on the 16th ready cycle.
        frame_d = 4'd0;
        if (ready_q) begin
            frame_d = frame_q + 4'd1;
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            delay_q <= 10'd0;
            ready_q <= 1'b0;
            frame_q <= 4'd0;
        end else begin
            delay_q <= delay_d;
            ready_q <= ready_d;
            frame_q <= frame_d;
        end
    end

    assign o_lvds_ready_ddr = ready_q;
    // Decoded from registers only, so the strobe drops together with ready.
    assign o_data_sbe_ddr   = ready_q && (frame_q == 4'd15);

endmodule

// File: tb/tb_lvds_clock_sync.sv
// Testbench for lvds_clock_sync with default parameters (START_DELAY=1000,
// TIMEOUT=100). The scenarios follow the LVDS_CLOCK_SYNC_WATCHDOG_EN setting of
// the build. Expected outputs per DDR cycle come from scenario arithmetic. They
// are pushed to a queue when the stimulus is driven and popped after the edge.

module tb_lvds_clock_sync;

    logic clk     = 1'b0;
    logic rst_b   = 1'b0;
    logic sys_clk = 1'b0;
    logic ready;
    logic sbe;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    lvds_clock_sync dut (
        .i_ddr_clk        (clk),
        .i_rst_b          (rst_b),
        .i_sys_clk        (sys_clk),
        .o_lvds_ready_ddr (ready),
        .o_data_sbe_ddr   (sbe)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is in the low clock phase. Drive sys_clk, queue the expected
    // outputs after the coming edge, then compare them once the edge has passed.
    task automatic step(input int k, input logic sys_val, input logic e_ready,
                        input logic e_sbe);
        logic [1:0] e;
        sys_clk = sys_val;
        exp_q.push_back({e_ready, e_sbe});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val($sformatf("queue@%0d", k), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val($sformatf("ready@%0d", k), ready, e[1]);
            check_val($sformatf("sbe@%0d", k), sbe, e[0]);
        end
        @(negedge clk);
    endtask

    // Edge k is the k-th rising edge after reset release. sys_clk toggles
    // every 3 cycles. Ready is expected from edge 1001, and strobes on ready
    // cycles 16, 32, and so on.
    task automatic run_from_release(input int last_k);
        logic e_rdy;
        for (int k = 1; k <= last_k; k++) begin
            e_rdy = (k >= 1001);
            step(k, (k % 3 == 0) ? ~sys_clk : sys_clk, e_rdy,
                 e_rdy && ((k - 1000) % 16 == 0));
        end
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_b = 1'b0;
        #1;
        check_val({tag, "_ready_async"}, ready, 1'b0);
        check_val({tag, "_sbe_async"}, sbe, 1'b0);
        @(posedge clk);
        #1;
        check_val({tag, "_ready_held"}, ready, 1'b0);
        check_val({tag, "_sbe_held"}, sbe, 1'b0);
        @(negedge clk);
        #2 rst_b = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic e_rdy;
        rst_b   = 1'b0;
        sys_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ready", ready, 1'b0);
        check_val("reset_sbe", sbe, 1'b0);
        @(negedge clk);
        #2 rst_b = 1'b1;

        // Start-up: ready rises at edge 1001, then frame strobes follow.
        run_from_release(1100);

`ifdef LVDS_CLOCK_SYNC_WATCHDOG_EN
        // The last toggle is sampled at edge 1098 and seen as an edge at 1100.
        // Lost at 1200, so ready falls at edge 1201.
        for (int k = 1101; k <= 1250; k++) begin
            e_rdy = (k <= 1200);
            step(k, sys_clk, e_rdy, e_rdy && ((k - 1000) % 16 == 0));
        end
        // Resume: the toggle sampled at 1251 is seen as an edge at 1253.
        // Ready returns 1001 cycles later, at edge 2254.
        for (int k = 1251; k <= 2300; k++) begin
            e_rdy = (k >= 2254);
            step(k, (k % 3 == 0) ? ~sys_clk : sys_clk, e_rdy,
                 e_rdy && ((k - 2253) % 16 == 0));
        end
`else
        // sys_clk frozen low: ready and strobes carry on regardless.
        for (int k = 1101; k <= 1400; k++) begin
            step(k, 1'b0, 1'b1, ((k - 1000) % 16 == 0));
        end
`endif

        // One-cycle reset pulse mid-frame, then a full restart.
        reset_pulse("rst_pulse");
        run_from_release(1040);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
